// File: rtl/gene_pack_fifo.sv
// Packs the gappy post-delete gene stream into a FWFT FIFO, counts node/conn genes
// and appends a count trailer. Optional drop counter: GENE_PACK_DROP_CNT_EN.
module gene_pack_fifo #(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               setup,
  input  logic               state,
  input  logic               last_in,
  input  logic [GENE_SZ-1:0] gene_in,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               out_valid,
  output logic               out_last,
  output logic [ATTR_SZ-1:0] node_cnt,
  output logic [ATTR_SZ-1:0] conn_cnt,
  output logic [ATTR_SZ-1:0] drop_cnt,
  output logic               overflow,
  output logic               done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ATTR_SZ-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, TRAIL, DONE} fsm_t;
  fsm_t fsm;

  logic [GENE_SZ-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        occ;
  logic               state_d, last_d;
  logic               full, empty, draining, push, pop, drop;

  assign empty    = (occ == '0);
  assign full     = (occ == (PW+1)'(DEPTH));
  assign draining = (fsm == STREAM) || (fsm == FLUSH);
  assign pop      = draining && !empty && out_ready;
  assign push     = !setup && (fsm == STREAM) && in_valid && (!full || pop);
  assign drop     = !setup && in_valid && !push;

  always_comb begin
    out_valid = 1'b0;
    gene_out  = '0;
    out_last  = 1'b0;
    if (draining && !empty) begin
      out_valid = 1'b1;
      gene_out  = mem[rd_ptr];
    end else if (fsm == TRAIL) begin
      out_valid = 1'b1;
      out_last  = 1'b1;
      gene_out  = {{(GENE_SZ-2*ATTR_SZ){1'b0}}, node_cnt, conn_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gene_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm      <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      state_d  <= 1'b0;
      last_d   <= 1'b0;
      node_cnt <= '0;
      conn_cnt <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else if (setup) begin
      fsm      <= STREAM;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      state_d  <= 1'b0;
      last_d   <= 1'b0;
      node_cnt <= '0;
      conn_cnt <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Delay state/last by one clock so they line up with the delete stage output.
      state_d <= state;
      last_d  <= last_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
      if (push) begin
        if (!state_d) begin
          if (node_cnt != CNT_MAX) node_cnt <= node_cnt + 1'b1;
        end else begin
          if (conn_cnt != CNT_MAX) conn_cnt <= conn_cnt + 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
      case (fsm)
        IDLE:    ;
        STREAM:  if (last_d) fsm <= FLUSH;
        FLUSH:   if (empty) fsm <= TRAIL;
        TRAIL:   if (out_ready) begin
                   fsm  <= DONE;
                   done <= 1'b1;
                 end
        DONE:    ;
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef GENE_PACK_DROP_CNT_EN
  logic [ATTR_SZ-1:0] drop_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            drop_q <= '0;
    else if (setup)                     drop_q <= '0;
    else if (drop && drop_q != CNT_MAX) drop_q <= drop_q + 1'b1;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gene_pack_fifo.sv
// Directed scoreboard bench for gene_pack_fifo: packing order, counts, trailer,
// full-FIFO drops, push+pop at full, deleted-last, async reset, empty genome.
module tb_gene_pack_fifo;

`ifdef GENE_PACK_DROP_CNT_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, setup, state, last_in, in_valid, out_ready;
  logic [63:0] gene_in, gene_out;
  logic        out_valid, out_last, overflow, done;
  logic [7:0]  node_cnt, conn_cnt, drop_cnt;

  gene_pack_fifo #(.GENE_SZ(64), .ATTR_SZ(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .setup(setup), .state(state), .last_in(last_in),
    .gene_in(gene_in), .in_valid(in_valid), .out_ready(out_ready),
    .gene_out(gene_out), .out_valid(out_valid), .out_last(out_last),
    .node_cnt(node_cnt), .conn_cnt(conn_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] g; logic l; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int en_node = 0, en_conn = 0;
  logic pv = 1'b0, pst = 1'b0, px = 1'b0;
  logic [63:0] pg = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", gene_out, 64'hx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("gene_out", gene_out, e.g);
        chk("out_last", {63'd0, out_last}, {63'd0, e.l});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives the pending gene (one clock behind its state/last) onto gene_in/in_valid.
  task automatic present();
    in_valid = pv;
    gene_in  = pg;
    if (pv && px) begin
      exp_q.push_back('{pg, 1'b0});
      if (pst) en_conn++; else en_node++;
    end
  endtask

  task automatic gene(input logic st, input logic lst, input logic v, input logic x,
                      input logic [63:0] g);
    present();
    state = st; last_in = lst;
    pv = v; pst = st; px = x; pg = g;
    tick();
  endtask

  task automatic flush_pipe();
    present();
    state = 1'b0; last_in = 1'b0; pv = 1'b0; px = 1'b0;
    tick();
    in_valid = 1'b0; gene_in = '0;
  endtask

  task automatic expect_trailer();
    logic [7:0] n, c;
    n = 8'(en_node); c = 8'(en_conn);
    exp_q.push_back('{{48'd0, n, c}, 1'b1});
  endtask

  task automatic do_setup();
    setup = 1'b1; tick(); setup = 1'b0;
    en_node = 0; en_conn = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin tick(); n++; end
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; setup = 1'b0; state = 1'b0; last_in = 1'b0;
    in_valid = 1'b0; gene_in = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0; tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_gene_out", gene_out, 64'd0);
    chk("rst_counts", {40'd0, node_cnt, conn_cnt, drop_cnt}, 64'd0);
    chk("rst_flags", {61'd0, out_last, overflow, done}, 64'd0);

    // T1: 3 node + 2 conn genes, streaming out immediately.
    out_ready = 1'b1;
    do_setup();
    for (int k = 0; k < 5; k++)
      gene(k >= 3, k == 4, 1'b1, 1'b1, 64'hA1A1_0000_0000_0000 | 64'(k));
    flush_pipe(); expect_trailer();
    chk("t1_trailer_model", {48'd0, 8'(en_node), 8'(en_conn)}, 64'h0302);
    wait_done("t1");
    chk("t1_counts", {48'd0, node_cnt, conn_cnt}, 64'h0302);
    chk("t1_overflow", {63'd0, overflow}, 64'd0);

    // T2: 20 genes into a stalled 16-deep FIFO; last 4 drop.
    out_ready = 1'b0;
    do_setup();
    chk("t2_setup_clear", {47'd0, node_cnt, conn_cnt, done}, 64'd0);
    for (int k = 0; k < 20; k++)
      gene(1'b0, k == 19, 1'b1, k < 16, 64'hB2B2_0000_0000_0000 | 64'(k));
    flush_pipe(); expect_trailer();
    tick();
    chk("t2_hold_gene", gene_out, 64'hB2B2_0000_0000_0000);
    tick();
    chk("t2_hold_gene2", gene_out, 64'hB2B2_0000_0000_0000);
    chk("t2_overflow", {63'd0, overflow}, 64'd1);
    chk("t2_node_cnt", {56'd0, node_cnt}, 64'd16);
    chk("t2_drop_cnt", {56'd0, drop_cnt}, DC ? 64'd4 : 64'd0);
    out_ready = 1'b1;
    wait_done("t2");

    // T3: fill to 16, then push and pop together every clock.
    out_ready = 1'b0;
    do_setup();
    for (int k = 0; k < 17; k++)
      gene(1'b0, 1'b0, 1'b1, 1'b1, 64'hC3C3_0000_0000_0000 | 64'(k));
    out_ready = 1'b1;
    for (int k = 17; k < 27; k++)
      gene(1'b0, k == 26, 1'b1, 1'b1, 64'hC3C3_0000_0000_0000 | 64'(k));
    chk("t3_out_valid", {63'd0, out_valid}, 64'd1);
    flush_pipe(); expect_trailer();
    chk("t3_overflow", {63'd0, overflow}, 64'd0);
    wait_done("t3");
    chk("t3_node_cnt", {56'd0, node_cnt}, 64'd27);
    chk("t3_drop_cnt", {56'd0, drop_cnt}, 64'd0);

    // T4: alternating deleted genes; last_in lands on a deleted one.
    do_setup();
    gene(1'b0, 1'b0, 1'b1, 1'b1, 64'hD4D4_0000_0000_0001);
    gene(1'b0, 1'b0, 1'b0, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
    gene(1'b1, 1'b0, 1'b1, 1'b1, 64'hD4D4_0000_0000_0003);
    gene(1'b1, 1'b1, 1'b0, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
    flush_pipe(); expect_trailer();
    wait_done("t4");
    chk("t4_counts", {48'd0, node_cnt, conn_cnt}, 64'h0101);
    chk("t4_overflow", {63'd0, overflow}, 64'd0);

    // T5: async reset with 7 entries queued, then a fresh genome.
    out_ready = 1'b0;
    do_setup();
    for (int k = 0; k < 7; k++)
      gene(k >= 4, 1'b0, 1'b1, 1'b1, 64'hE5E5_0000_0000_0000 | 64'(k));
    flush_pipe();
    chk("t5_pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1; #2;
    chk("t5_rst_gene_out", gene_out, 64'd0);
    chk("t5_rst_outs", {45'd0, out_valid, out_last, overflow, done, node_cnt, conn_cnt}, 64'd0);
    exp_q.delete();
    tick(); rst = 1'b0; tick();
    out_ready = 1'b1;
    do_setup();
    gene(1'b0, 1'b0, 1'b1, 1'b1, 64'h5555_0000_0000_0001);
    gene(1'b0, 1'b0, 1'b1, 1'b1, 64'h5555_0000_0000_0002);
    gene(1'b1, 1'b1, 1'b1, 1'b1, 64'h5555_0000_0000_0003);
    flush_pipe(); expect_trailer();
    wait_done("t5");
    chk("t5_counts", {48'd0, node_cnt, conn_cnt}, 64'h0201);

    // T6: empty genome, last on the first cycle.
    do_setup();
    gene(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    flush_pipe(); expect_trailer();
    wait_done("t6");
    chk("t6_counts", {48'd0, node_cnt, conn_cnt}, 64'd0);

    // A gene arriving after the trailer is ignored but flagged.
    in_valid = 1'b1; gene_in = 64'hF00D; tick();
    in_valid = 1'b0; gene_in = '0; tick();
    chk("late_overflow", {63'd0, overflow}, 64'd1);
    chk("late_drop_cnt", {56'd0, drop_cnt}, DC ? 64'd1 : 64'd0);
    chk("late_no_output", {63'd0, out_valid}, 64'd0);
    do_setup();
    chk("setup_clears", {54'd0, overflow, done, drop_cnt}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
